// File: rtl/conv2d_stream_engine_if.sv
// ---------------------------------------------------------------------------
// conv2d_stream_engine_if
// Bundles the control, coefficient-load, pixel-in and result-out signals of
// conv2d_stream_engine into a single interface.
//   slave  modport : engine side (inputs from the host, outputs to it)
//   master modport : host / producer / consumer side
// Signals:
//   in_st      start pulse                 busy      frame in progress
//   done       last result accepted pulse  coef_we   coefficient write strobe
//   coef_addr  coefficient index (row-major) coef_din signed coefficient
//   pix_valid/pix_ready/pix_din            pixel stream (unsigned)
//   out_valid/out_ready/dout/out_last      result stream (signed)
// ---------------------------------------------------------------------------
interface conv2d_stream_engine_if #(
  parameter int K      = 3,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 16
);
  localparam int ADDR_W = (K * K > 1) ? $clog2(K * K) : 1;

  logic                     in_st;
  logic                     busy;
  logic                     done;
  logic                     coef_we;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [COEF_W-1:0] coef_din;
  logic                     pix_valid;
  logic                     pix_ready;
  logic [DATA_W-1:0]        pix_din;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  dout;
  logic                     out_last;

  modport slave (
    input  in_st, coef_we, coef_addr, coef_din, pix_valid, pix_din, out_ready,
    output busy, done, pix_ready, out_valid, dout, out_last
  );

  modport master (
    output in_st, coef_we, coef_addr, coef_din, pix_valid, pix_din, out_ready,
    input  busy, done, pix_ready, out_valid, dout, out_last
  );
endinterface

// File: rtl/conv2d_stream_engine.sv
// ---------------------------------------------------------------------------
// conv2d_stream_engine
// Streaming KxK 2D convolution over an IMG_W x IMG_H raster-order image.
// Pixels enter through a valid/ready port and fill a pixel delay line that
// spans K-1 image lines plus K-1 pixels, so every KxK window is available
// the moment its bottom-right pixel arrives. Each complete window yields one
// saturated signed result on a registered valid/ready output port.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : conv2d_stream_engine_if.slave (control, coefficients, pixel and
//          result streams)
// Build option:
//   CONV_RELU_EN : when defined, negative saturated results are clamped to 0.
// ---------------------------------------------------------------------------
module conv2d_stream_engine #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 16
) (
  input logic                   clk,
  input logic                   rst,
  conv2d_stream_engine_if.slave bus
);
  localparam int NTAP      = K * K;
  localparam int ADDR_W    = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int NPIX      = IMG_W * IMG_H;
  localparam int COL_W     = $clog2(IMG_W + 1);
  localparam int ROW_W     = $clog2(IMG_H + 1);
  localparam int PIX_W     = $clog2(NPIX + 1);
  localparam int PROD_W    = DATA_W + 1 + COEF_W;
  localparam int SUM_W     = DATA_W + COEF_W + 2 * $clog2(K) + 1;
  localparam int SHIFT_LEN = (K > 1) ? (K - 1) * IMG_W + K - 1 : 1;

  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(64'sd1 <<< (ACC_W - 1)));

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                   r_state;
  state_t                   w_stateNext;
  logic                     w_doneNext;
  logic                     r_done;
  logic [COL_W-1:0]         r_col;
  logic [ROW_W-1:0]         r_row;
  logic [PIX_W-1:0]         r_pixCnt;
  logic [DATA_W-1:0]        r_shift [SHIFT_LEN];
  logic [DATA_W-1:0]        w_win   [SHIFT_LEN+1];
  logic signed [COEF_W-1:0] r_coef  [NTAP];
  logic                     r_outValid;
  logic                     r_outLast;
  logic signed [ACC_W-1:0]  r_dout;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_sat;
  logic signed [ACC_W-1:0]  w_result;
  logic                     w_start;
  logic                     w_pixReady;
  logic                     w_pixFire;
  logic                     w_outFire;
  logic                     w_winDone;
  logic                     w_lastPix;
  logic                     w_addrOk;

  assign w_addrOk   = ({{(32 - ADDR_W){1'b0}}, bus.coef_addr} < 32'(NTAP));
  assign w_pixReady = (r_state == S_RUN) && (!r_outValid || bus.out_ready) &&
                      (r_pixCnt < PIX_W'(NPIX));
  assign w_pixFire  = bus.pix_valid && w_pixReady;
  assign w_outFire  = r_outValid && bus.out_ready;
  assign w_winDone  = w_pixFire && (r_row >= ROW_W'(K - 1)) && (r_col >= COL_W'(K - 1));
  assign w_lastPix  = (r_pixCnt == PIX_W'(NPIX - 1));
  assign w_start    = (r_state == S_IDLE) && (w_stateNext == S_RUN);

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_done  <= w_doneNext;
    end
  end

  // A start is refused during the done pulse so a start held across the end
  // of a frame cannot silently launch the next one.
  always_comb begin
    w_stateNext = r_state;
    w_doneNext  = 1'b0;
    if (r_state == S_IDLE) begin
      if (bus.in_st && !r_done) w_stateNext = S_RUN;
    end else if (w_outFire && r_outLast) begin
      w_stateNext = S_IDLE;
      w_doneNext  = 1'b1;
    end
  end

  // Coefficients are only writable between frames so a running frame always
  // sees one consistent kernel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NTAP; n++) r_coef[n] <= '0;
    end else if ((r_state == S_IDLE) && bus.coef_we && w_addrOk) begin
      r_coef[bus.coef_addr] <= bus.coef_din;
    end
  end

  // Raster position and accepted-pixel count of the next incoming pixel.
  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_col    <= '0;
      r_row    <= '0;
      r_pixCnt <= '0;
    end else if (w_pixFire) begin
      r_pixCnt <= r_pixCnt + PIX_W'(1);
      if (r_col == COL_W'(IMG_W - 1)) begin
        r_col <= '0;
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Pixel delay line acting as the K-1 line buffers; contents left over
  // from an aborted frame never reach a result because the row/col gating
  // restarts with the new frame.
  always_ff @(posedge clk) begin
    if (w_pixFire) begin
      r_shift[0] <= bus.pix_din;
      for (int n = 1; n < SHIFT_LEN; n++) r_shift[n] <= r_shift[n-1];
    end
  end

  // Window taps by age: age 0 is the pixel on the input right now, age a is
  // the pixel accepted a pixels earlier.
  always_comb begin
    w_win[0] = bus.pix_din;
    for (int n = 0; n < SHIFT_LEN; n++) w_win[n+1] = r_shift[n];
  end

  // Coefficient (i,j) meets the pixel i rows and j columns from the window's
  // top-left, i.e. (K-1-i) lines and (K-1-j) pixels older than the input.
  always_comb begin
    w_prod = '0;
    w_sum  = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        w_prod = $signed({1'b0, w_win[(K - 1 - i) * IMG_W + (K - 1 - j)]}) * r_coef[i * K + j];
        w_sum  = w_sum + SUM_W'(w_prod);
      end
    end
  end

  // Clamp the full-precision sum into the output range.
  always_comb begin
    w_sat = w_sum[ACC_W-1:0];
    if (w_sum > SAT_MAX) begin
      w_sat = SAT_MAX[ACC_W-1:0];
    end else if (w_sum < SAT_MIN) begin
      w_sat = SAT_MIN[ACC_W-1:0];
    end
    w_result = w_sat;
`ifdef CONV_RELU_EN
    if (w_sat[ACC_W-1]) w_result = '0;
`endif
  end

  // A new result takes priority over retiring the old one, which lets a
  // handshake and a new window share a cycle without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
      r_dout     <= '0;
    end else if (w_winDone) begin
      r_outValid <= 1'b1;
      r_outLast  <= w_lastPix;
      r_dout     <= w_result;
    end else if (w_outFire) begin
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
    end
  end

  assign bus.busy      = (r_state == S_RUN);
  assign bus.done      = r_done;
  assign bus.pix_ready = w_pixReady;
  assign bus.out_valid = r_outValid;
  assign bus.out_last  = r_outLast;
  assign bus.dout      = r_dout;

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// ---------------------------------------------------------------------------
// tb_conv2d_stream_engine
// Self-checking bench for conv2d_stream_engine: a default 8x8 / 3x3 instance
// is checked against a direct convolution model, and a 5x4 instance against
// hand-computed results.
// ---------------------------------------------------------------------------
module tb_conv2d_stream_engine;
  localparam int W    = 8;
  localparam int H    = 8;
  localparam int K    = 3;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int AW   = 16;
  localparam int NPIX = W * H;
  localparam int SW   = 5;
  localparam int SH   = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  conv2d_stream_engine_if #(.K(K), .DATA_W(DW), .COEF_W(CW), .ACC_W(AW)) v ();
  conv2d_stream_engine_if #(.K(K), .DATA_W(DW), .COEF_W(CW), .ACC_W(AW)) sv ();

  conv2d_stream_engine #(
    .IMG_W(W), .IMG_H(H), .K(K), .DATA_W(DW), .COEF_W(CW), .ACC_W(AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (v.slave)
  );

  conv2d_stream_engine #(
    .IMG_W(SW), .IMG_H(SH), .K(K), .DATA_W(DW), .COEF_W(CW), .ACC_W(AW)
  ) dutSmall (
    .clk (clk),
    .rst (rst),
    .bus (sv.slave)
  );

  typedef struct {
    longint d;
    bit     last;
  } exp_t;

  exp_t   expQ[$];
  int     img  [H][W];
  int     kern [K][K];
  int     total     = 0;
  int     passed    = 0;
  bit     chkEn     = 1'b0;
  bit     prevStall = 1'b0;
  bit     pendDone  = 1'b0;
  longint prevDout  = 0;

  task automatic checkOutput(input string name, input longint act, input longint expv);
    total++;
    if (act == expv) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  function automatic longint satRelu(input longint s);
    longint mx;
    longint mn;
    longint r;
    mx = (longint'(1) <<< (AW - 1)) - 1;
    mn = -(longint'(1) <<< (AW - 1));
    r  = s;
    if (r > mx) r = mx;
    else if (r < mn) r = mn;
`ifdef CONV_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  // Direct convolution of the current image with the current kernel.
  task automatic buildExpected();
    longint s;
    expQ.delete();
    for (int r = K - 1; r < H; r++) begin
      for (int c = K - 1; c < W; c++) begin
        s = 0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            s += longint'(img[r-K+1+i][c-K+1+j]) * longint'(kern[i][j]);
        expQ.push_back('{d: satRelu(s), last: (r == H - 1) && (c == W - 1)});
      end
    end
  endtask

  // Writes the model kernel into the engine, plus junk at out-of-range addresses.
  task automatic loadKernel();
    for (int a = 0; a < 16; a++) begin
      v.coef_we   = 1'b1;
      v.coef_addr = 4'(a);
      v.coef_din  = (a < K * K) ? 8'(kern[a/K][a%K]) : 8'($urandom);
      @(posedge clk) #1;
    end
    v.coef_we = 1'b0;
  endtask

  // Per-cycle output checker against the model queue.
  always @(negedge clk) begin
    exp_t e;
    if (chkEn && !rst) begin
      checkOutput("done", v.done, pendDone);
      pendDone = 1'b0;
      if (prevStall) begin
        checkOutput("hold out_valid", v.out_valid, 1);
        checkOutput("hold dout", v.dout, prevDout);
      end
      if (v.out_valid && !v.out_ready) checkOutput("pix_ready while stalled", v.pix_ready, 0);
      if (v.out_valid && v.out_ready) begin
        checkOutput("result expected", expQ.size() > 0, 1);
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkOutput("dout", v.dout, e.d);
          checkOutput("out_last", v.out_last, e.last);
          pendDone = e.last;
        end
      end
      prevStall = v.out_valid && !v.out_ready;
      prevDout  = v.dout;
    end
  end

  // Runs one frame. stall randomises out_ready/pix_valid, ctrl injects in_st
  // and coef_we noise while running, abortAt>0 resets after that many pixels.
  task automatic applyStimulus(input bit stall, input bit ctrl, input int abortAt);
    int sent      = 0;
    int cyc       = 0;
    bit acc       = 1'b0;
    bit frameDone = 1'b0;
    bit expVal    = 1'b0;
    buildExpected();
    v.in_st = 1'b1;
    @(posedge clk) #1;
    v.in_st = 1'b0;
    checkOutput("busy at start", v.busy, 1);
    while (!frameDone && cyc < 4000) begin
      cyc++;
      v.pix_valid = (sent < NPIX) && (!stall || $urandom_range(0, 3) != 0);
      v.pix_din   = (sent < NPIX) ? 8'(img[sent/W][sent%W]) : 8'($urandom);
      v.out_ready = !stall || ($urandom_range(0, 1) == 1);
      if (ctrl) begin
        v.in_st     = ($urandom_range(0, 3) == 0);
        v.coef_we   = (sent < NPIX) && ($urandom_range(0, 1) == 1);
        v.coef_addr = 4'($urandom);
        v.coef_din  = 8'($urandom);
      end
      @(negedge clk);
      if (!stall) checkOutput("out_valid latency", v.out_valid, expVal);
      acc    = v.pix_valid && v.pix_ready;
      expVal = acc && (sent / W >= K - 1) && (sent % W >= K - 1);
      if (acc) sent++;
      if (v.done) frameDone = 1'b1;
      @(posedge clk) #1;
      if (abortAt > 0 && sent == abortAt) break;
    end
    v.in_st     = 1'b0;
    v.coef_we   = 1'b0;
    v.pix_valid = 1'b0;
    if (abortAt > 0) begin
      checkOutput("abort point reached", sent, abortAt);
      rst = 1'b1;
      @(posedge clk) #1;
      checkOutput("busy after rst", v.busy, 0);
      checkOutput("out_valid after rst", v.out_valid, 0);
      rst       = 1'b0;
      expQ.delete();
      prevStall = 1'b0;
      pendDone  = 1'b0;
      for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) kern[i][j] = 0;
    end else begin
      checkOutput("frame finished", frameDone, 1);
      checkOutput("busy after done", v.busy, 0);
      checkOutput("results left over", expQ.size(), 0);
    end
    v.out_ready = 1'b1;
    @(posedge clk) #1;
  endtask

  task automatic setKernel(input int val);
    for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) kern[i][j] = val;
  endtask

  task automatic setImage(input int mode, input int val);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (mode == 0) ? (r * W + c) : (mode == 1) ? val : int'($urandom_range(0, 255));
  endtask

  task automatic runSmall();
    longint got[$];
    bit     lastQ[$];
    longint want[6] = '{63, 72, 81, 108, 117, 126};
    int     n   = 0;
    int     cyc = 0;
    for (int a = 0; a < K * K; a++) begin
      sv.coef_we   = 1'b1;
      sv.coef_addr = 4'(a);
      sv.coef_din  = 8'sd1;
      @(posedge clk) #1;
    end
    sv.coef_we = 1'b0;
    sv.in_st   = 1'b1;
    @(posedge clk) #1;
    sv.in_st = 1'b0;
    while (got.size() < 6 && cyc < 300) begin
      cyc++;
      sv.pix_valid = (n < SW * SH);
      sv.pix_din   = 8'(n + 1);
      @(negedge clk);
      if (sv.pix_valid && sv.pix_ready) n++;
      if (sv.out_valid && sv.out_ready) begin
        got.push_back(sv.dout);
        lastQ.push_back(sv.out_last);
      end
      @(posedge clk) #1;
    end
    sv.pix_valid = 1'b0;
    checkOutput("small result count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checkOutput("small dout", got[i], want[i]);
      checkOutput("small out_last", lastQ[i], (i == 5) ? 1 : 0);
    end
    checkOutput("small done", sv.done, 1);
    @(posedge clk) #1;
    checkOutput("small busy after done", sv.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    v.in_st = 0;  v.coef_we = 0;  v.coef_addr = '0; v.coef_din = '0;
    v.pix_valid = 0; v.pix_din = '0; v.out_ready = 1'b1;
    sv.in_st = 0; sv.coef_we = 0; sv.coef_addr = '0; sv.coef_din = '0;
    sv.pix_valid = 0; sv.pix_din = '0; sv.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", v.busy, 0);
    checkOutput("reset done", v.done, 0);
    checkOutput("reset pix_ready", v.pix_ready, 0);
    checkOutput("reset out_valid", v.out_valid, 0);
    checkOutput("reset out_last", v.out_last, 0);
    checkOutput("reset dout", v.dout, 0);
    rst   = 1'b0;
    chkEn = 1'b1;
    @(posedge clk) #1;

    $display("[TB] identity kernel, ramp image");
    setKernel(0);
    kern[1][1] = 1;
    setImage(0, 0);
    buildExpected();
    checkOutput("model identity count", expQ.size(), 36);
    checkOutput("model identity first", expQ[0].d, 9);
    checkOutput("model identity row2", expQ[6].d, 17);
    checkOutput("model identity last", expQ[35].d, 54);
    loadKernel();
    applyStimulus(1'b0, 1'b0, 0);

    $display("[TB] all-ones kernel, constant image");
    setKernel(1);
    setImage(1, 10);
    buildExpected();
    checkOutput("model ones", expQ[0].d, 90);
    loadKernel();
    applyStimulus(1'b0, 1'b0, 0);

    $display("[TB] positive saturation");
    setKernel(127);
    setImage(1, 255);
    buildExpected();
    checkOutput("model sat max", expQ[0].d, 32767);
    loadKernel();
    applyStimulus(1'b0, 1'b0, 0);

    $display("[TB] negative saturation");
    setKernel(-128);
    buildExpected();
`ifdef CONV_RELU_EN
    checkOutput("model sat min relu", expQ[0].d, 0);
`else
    checkOutput("model sat min", expQ[0].d, -32768);
`endif
    loadKernel();
    applyStimulus(1'b1, 1'b0, 0);

    $display("[TB] random kernel and image, backpressure and control noise");
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) kern[i][j] = int'($urandom_range(0, 255)) - 128;
    setImage(2, 0);
    loadKernel();
    applyStimulus(1'b1, 1'b1, 0);
    applyStimulus(1'b0, 1'b0, 0);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 1'b0, 30);
    setImage(2, 0);
    applyStimulus(1'b0, 1'b0, 0);
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) kern[i][j] = int'($urandom_range(0, 255)) - 128;
    loadKernel();
    applyStimulus(1'b1, 1'b0, 0);

    $display("[TB] 5x4 image instance");
    runSmall();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
